layer_mem_arbiter: RTL and testbench

//  Shares the single CONV layer-memory port between N requesters, e.g. conv-writer, maxpool-engine, flatten-writer.
//  The shared port is csel / cwr / caddr_wr / cdata_wr / crd / caddr_rd / cdata_rd.

---
 rtl/layer_mem_arbiter_pkg.sv | 32 +++
 rtl/layer_mem_arbiter_if.sv | 39 +++
 rtl/layer_mem_arbiter_rr_arbiter.sv | 82 ++++++++
 rtl/layer_mem_arbiter.sv | 96 +++++++++
 tb/tb_layer_mem_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/layer_mem_arbiter_pkg.sv
// Shared constants and types for the layer-memory arbiter.
//   LM_*    : default address/data/select widths and requester count
//   csel_e  : layer-memory select codes; 0 and >5 are illegal targets
//   arb_state_e : round-robin arbiter lock state
//   sel_bad : flags an illegal memory select
package layer_mem_arbiter_pkg;

  localparam int unsigned LM_AW   = 12;
  localparam int unsigned LM_DW   = 20;
  localparam int unsigned LM_SW   = 3;
  localparam int unsigned LM_NREQ = 3;

  typedef enum logic [LM_SW-1:0] {
    CSEL_NONE  = 3'd0,
    CSEL_L0_K0 = 3'd1,
    CSEL_L0_K1 = 3'd2,
    CSEL_L1_K0 = 3'd3,
    CSEL_L1_K1 = 3'd4,
    CSEL_L2    = 3'd5
  } csel_e;

  typedef enum logic {
    ARB_OPEN   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // True for a select outside CSEL_L0_K0..CSEL_L2.
  function automatic logic sel_bad(input logic [31:0] sel);
    return (sel == 32'(CSEL_NONE)) || (sel > 32'(CSEL_L2));
  endfunction

endpackage

// File: rtl/layer_mem_arbiter_if.sv
// Requester side and memory side of the shared layer-memory port.
//   slave  : the arbiter (takes requests and cdata_rd, drives grants and the memory command)
//   master : the layer engines plus the layer memory
interface layer_mem_arbiter_if
  import layer_mem_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = LM_NREQ,
  parameter int unsigned AW    = LM_AW,
  parameter int unsigned DW    = LM_DW,
  parameter int unsigned SW    = LM_SW
);
  logic [N_REQ-1:0]    req;
  logic [N_REQ-1:0]    req_wr;
  logic [N_REQ-1:0]    req_lock;
  logic [N_REQ*SW-1:0] req_sel;
  logic [N_REQ*AW-1:0] req_addr;
  logic [N_REQ*DW-1:0] req_wdata;
  logic [N_REQ-1:0]    gnt;
  logic [N_REQ-1:0]    rvalid;
  logic [DW-1:0]       rdata;
  logic                err_sel;
  logic                cwr;
  logic [AW-1:0]       caddr_wr;
  logic [DW-1:0]       cdata_wr;
  logic                crd;
  logic [AW-1:0]       caddr_rd;
  logic [DW-1:0]       cdata_rd;
  logic [SW-1:0]       csel;

  modport slave (
    input  req, req_wr, req_lock, req_sel, req_addr, req_wdata, cdata_rd,
    output gnt, rvalid, rdata, err_sel, cwr, caddr_wr, cdata_wr, crd, caddr_rd, csel
  );

  modport master (
    output req, req_wr, req_lock, req_sel, req_addr, req_wdata, cdata_rd,
    input  gnt, rvalid, rdata, err_sel, cwr, caddr_wr, cdata_wr, crd, caddr_rd, csel
  );
endinterface

// File: rtl/layer_mem_arbiter_rr_arbiter.sv
// N-input round-robin arbiter with grant lock.
//   clk, reset : clock, async active-high reset
//   req        : per-input request
//   lock_req   : hold the grant after this accept
//   gnt_c      : one-hot grant (combinational)
//   idx_c      : index of the granted input (valid when gnt_c != 0)
module rr_arbiter
  import layer_mem_arbiter_pkg::*;
#(
  parameter  int unsigned N  = 3,
  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  lock_req,
  output logic [N-1:0]  gnt_c,
  output logic [PW-1:0] idx_c
);

  arb_state_e    state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] owner_q, owner_d;
  logic          found;
  int unsigned   cand;

  // State, pointer and owner registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ARB_OPEN;
      ptr_q   <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
    end
  end

  // Grant selection and next state; a grant is only ever given to a requesting input,
  // so found doubles as "accepted this cycle".
  always_comb begin
    gnt_c   = '0;
    idx_c   = '0;
    found   = 1'b0;
    cand    = 0;
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;

    if (state_q == ARB_LOCKED) begin
      if (req[owner_q]) begin
        gnt_c[owner_q] = 1'b1;
        idx_c          = owner_q;
        found          = 1'b1;
      end else begin
        state_d = ARB_OPEN;
      end
    end else begin
      for (int unsigned k = 0; k < N; k++) begin
        cand = 32'(ptr_q) + k;
        if (cand >= N) cand = cand - N;
        if (!found && req[PW'(cand)]) begin
          found             = 1'b1;
          gnt_c[PW'(cand)]  = 1'b1;
          idx_c             = PW'(cand);
        end
      end
    end

    if (found) begin
      owner_d = idx_c;
      if (lock_req[idx_c]) begin
        state_d = ARB_LOCKED;
      end else begin
        state_d = ARB_OPEN;
        ptr_d   = (32'(idx_c) + 32'd1 == N) ? '0 : PW'(32'(idx_c) + 32'd1);
      end
    end
  end

endmodule

// File: rtl/layer_mem_arbiter.sv
// Shares one layer-memory port between N_REQ engines with round-robin + lock.
//   clk, reset : clock, async active-high reset
//   bus        : requester handshake (req/gnt/rvalid/rdata/err_sel) and the
//                registered memory command (cwr/crd/caddr_*/cdata_wr/csel, cdata_rd in)
// Accept at t -> command at t+1 -> read data returned with rvalid at t+2.
module layer_mem_arbiter
  import layer_mem_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = LM_NREQ,
  parameter int unsigned AW    = LM_AW,
  parameter int unsigned DW    = LM_DW,
  parameter int unsigned SW    = LM_SW
) (
  input logic               clk,
  input logic               reset,
  layer_mem_arbiter_if.slave bus
);

  localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0] gnt_c;
  logic [PW-1:0]    gidx_c;
  logic             accept_c;
  logic             wr_c;
  logic [SW-1:0]    sel_c;
  logic [AW-1:0]    addr_c;
  logic [DW-1:0]    wdata_c;

  logic             cwr_q, crd_q, err_q;
  logic [SW-1:0]    csel_q;
  logic [AW-1:0]    caddr_wr_q, caddr_rd_q;
  logic [DW-1:0]    cdata_wr_q, rdata_q;
  logic [N_REQ-1:0] tag_q, rvalid_q;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .clk      (clk),
    .reset    (reset),
    .req      (bus.req),
    .lock_req (bus.req_lock),
    .gnt_c    (gnt_c),
    .idx_c    (gidx_c)
  );

  // Payload of the granted requester.
  always_comb begin
    accept_c = |(bus.req & gnt_c);
    wr_c     = bus.req_wr[gidx_c];
    sel_c    = bus.req_sel[32'(gidx_c)*SW +: SW];
    addr_c   = bus.req_addr[32'(gidx_c)*AW +: AW];
    wdata_c  = bus.req_wdata[32'(gidx_c)*DW +: DW];
  end

  // Command stage and read-tag pipeline; tag_q marks the issuer of the read in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cwr_q      <= 1'b0;
      crd_q      <= 1'b0;
      csel_q     <= '0;
      caddr_wr_q <= '0;
      caddr_rd_q <= '0;
      cdata_wr_q <= '0;
      err_q      <= 1'b0;
      tag_q      <= '0;
      rvalid_q   <= '0;
      rdata_q    <= '0;
    end else begin
      cwr_q    <= accept_c & wr_c;
      crd_q    <= accept_c & ~wr_c;
      tag_q    <= (accept_c && !wr_c) ? gnt_c : '0;
      rvalid_q <= tag_q;
      if (|tag_q) rdata_q <= bus.cdata_rd;
      if (accept_c) begin
        csel_q <= sel_c;
        if (wr_c) begin
          caddr_wr_q <= addr_c;
          cdata_wr_q <= wdata_c;
        end else begin
          caddr_rd_q <= addr_c;
        end
        if (sel_bad(32'(sel_c))) err_q <= 1'b1;
      end
    end
  end

  assign bus.gnt      = gnt_c;
  assign bus.cwr      = cwr_q;
  assign bus.crd      = crd_q;
  assign bus.csel     = csel_q;
  assign bus.caddr_wr = caddr_wr_q;
  assign bus.caddr_rd = caddr_rd_q;
  assign bus.cdata_wr = cdata_wr_q;
  assign bus.err_sel  = err_q;
  assign bus.rvalid   = rvalid_q;
  assign bus.rdata    = rdata_q;

endmodule

// File: tb/tb_layer_mem_arbiter.sv
// Directed bench for layer_mem_arbiter with a behavioural model checked every cycle.
module tb_layer_mem_arbiter;
  import layer_mem_arbiter_pkg::*;

  localparam int unsigned N  = 3;
  localparam int unsigned AW = 12;
  localparam int unsigned DW = 20;
  localparam int unsigned SW = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  layer_mem_arbiter_if #(.N_REQ(N), .AW(AW), .DW(DW), .SW(SW)) bus ();

  layer_mem_arbiter #(.N_REQ(N), .AW(AW), .DW(DW), .SW(SW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Background memory content for never-written addresses.
  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return {8'h00, a} ^ 20'h5A5A5;
  endfunction

  // Layer memory owned by the bench.
  logic [DW-1:0] mem   [1<<AW];
  bit            mem_w [1<<AW];
  always @(posedge clk) begin
    if (bus.cwr) begin
      mem[bus.caddr_wr]   <= bus.cdata_wr;
      mem_w[bus.caddr_wr] <= 1'b1;
    end
  end
  assign bus.cdata_rd = mem_w[bus.caddr_rd] ? mem[bus.caddr_rd] : pat(bus.caddr_rd);

  // Per-requester stimulus, packed onto the bus.
  logic [N-1:0]  t_req, t_wr, t_lock;
  logic [SW-1:0] t_sel   [N];
  logic [AW-1:0] t_addr  [N];
  logic [DW-1:0] t_wdata [N];

  always_comb begin
    bus.req       = t_req;
    bus.req_wr    = t_wr;
    bus.req_lock  = t_lock;
    bus.req_sel   = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    for (int i = 0; i < N; i++) begin
      bus.req_sel[i*SW +: SW]   = t_sel[i];
      bus.req_addr[i*AW +: AW]  = t_addr[i];
      bus.req_wdata[i*DW +: DW] = t_wdata[i];
    end
  end

  // ---------------- behavioural model ----------------
  int            m_ptr, m_owner, m_g, c_iss;
  bit            m_lock, m_err, c_wr, c_rd;
  logic [SW-1:0] h_sel, m_s;
  logic [AW-1:0] h_awr, h_ard;
  logic [DW-1:0] h_wd, e_rdata;
  logic [N-1:0]  e_rv, m_gnt;
  logic [DW-1:0] mm [int];

  function automatic logic [DW-1:0] mread(input logic [AW-1:0] a);
    return mm.exists(int'(a)) ? mm[int'(a)] : pat(a);
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      m_ptr = 0; m_owner = 0; m_lock = 0; m_err = 0;
      c_wr = 0; c_rd = 0; c_iss = 0;
      h_sel = '0; h_awr = '0; h_ard = '0; h_wd = '0;
      e_rv = '0; e_rdata = '0;
      chk("rst_cwr", 32'(bus.cwr), 32'd0);
      chk("rst_crd", 32'(bus.crd), 32'd0);
      chk("rst_rvalid", 32'(bus.rvalid), 32'd0);
      chk("rst_err_sel", 32'(bus.err_sel), 32'd0);
      chk("rst_csel", 32'(bus.csel), 32'd0);
    end else begin
      // Who must be granted this cycle.
      m_g = -1;
      if (m_lock) begin
        if (bus.req[m_owner]) m_g = m_owner;
      end else begin
        for (int k = 0; k < N; k++) begin
          if (m_g < 0 && bus.req[(m_ptr + k) % N]) m_g = (m_ptr + k) % N;
        end
      end
      m_gnt = (m_g >= 0) ? N'(1 << m_g) : '0;

      chk("gnt", 32'(bus.gnt), 32'(m_gnt));
      chk("cwr", 32'(bus.cwr), 32'(c_wr));
      chk("crd", 32'(bus.crd), 32'(c_rd));
      chk("csel", 32'(bus.csel), 32'(h_sel));
      chk("caddr_wr", 32'(bus.caddr_wr), 32'(h_awr));
      chk("caddr_rd", 32'(bus.caddr_rd), 32'(h_ard));
      chk("cdata_wr", 32'(bus.cdata_wr), 32'(h_wd));
      chk("rvalid", 32'(bus.rvalid), 32'(e_rv));
      if (e_rv != '0) chk("rdata", 32'(bus.rdata), 32'(e_rdata));
      chk("err_sel", 32'(bus.err_sel), 32'(m_err));

      // The command now on the port completes at the coming edge.
      e_rv = c_rd ? N'(1 << c_iss) : '0;
      if (c_rd) e_rdata = mread(h_ard);
      if (c_wr) mm[int'(h_awr)] = h_wd;
      c_wr = 0;
      c_rd = 0;

      if (m_lock && !bus.req[m_owner]) m_lock = 0;
      if (m_g >= 0) begin
        c_iss = m_g;
        m_s   = bus.req_sel[m_g*SW +: SW];
        h_sel = m_s;
        if (bus.req_wr[m_g]) begin
          c_wr  = 1;
          h_awr = bus.req_addr[m_g*AW +: AW];
          h_wd  = bus.req_wdata[m_g*DW +: DW];
        end else begin
          c_rd  = 1;
          h_ard = bus.req_addr[m_g*AW +: AW];
        end
        if (m_s == 0 || m_s > 5) m_err = 1;
        m_owner = m_g;
        m_lock  = bus.req_lock[m_g];
        if (!m_lock) m_ptr = (m_g + 1) % N;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    t_req  = '0;
    t_wr   = '0;
    t_lock = '0;
  endtask

  task automatic rq(input int i, input bit wr, input bit lk, input logic [SW-1:0] s,
                    input logic [AW-1:0] a, input logic [DW-1:0] d);
    t_req[i]   = 1'b1;
    t_wr[i]    = wr;
    t_lock[i]  = lk;
    t_sel[i]   = s;
    t_addr[i]  = a;
    t_wdata[i] = d;
  endtask

  logic [N-1:0]  seq2 [6];
  logic [N-1:0]  seq3 [6];
  logic [AW-1:0] adr3 [4];
  bit            lk3  [4];

  initial begin
    seq2 = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    seq3 = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b100, 3'b001};
    adr3 = '{12'h000, 12'h040, 12'h001, 12'h041};
    lk3  = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < N; i++) begin
      t_sel[i] = '0; t_addr[i] = '0; t_wdata[i] = '0;
    end
    clr();
    reset = 1'b1;
    repeat (3) step();
    chk("reset_gnt", 32'(bus.gnt), 32'd0);
    chk("reset_rvalid", 32'(bus.rvalid), 32'd0);
    chk("reset_crd", 32'(bus.crd), 32'd0);
    reset = 1'b0;
    step();

    // 1: single read by requester 1
    rq(1, 0, 0, 3'd3, 12'h041, '0);
    #1 chk("t1_gnt", 32'(bus.gnt), 32'h2);
    step(); clr();
    chk("t1_crd", 32'(bus.crd), 32'd1);
    chk("t1_caddr_rd", 32'(bus.caddr_rd), 32'h041);
    chk("t1_csel", 32'(bus.csel), 32'd3);
    step();
    chk("t1_rvalid", 32'(bus.rvalid), 32'h2);
    chk("t1_rdata", 32'(bus.rdata), 32'h5A5E4);

    // pointer is now 2; one access by requester 2 brings it back to 0
    rq(2, 0, 0, 3'd5, 12'h100, '0);
    #1 chk("p2_gnt", 32'(bus.gnt), 32'h4);
    step(); clr();

    // 2: everyone requests every cycle
    for (int k = 0; k < 6; k++) begin
      rq(0, 0, 0, 3'd1, AW'(k), '0);
      rq(1, 0, 0, 3'd2, AW'(k + 16), '0);
      rq(2, 0, 0, 3'd4, AW'(k + 32), '0);
      #1 chk("t2_gnt", 32'(bus.gnt), 32'(seq2[k]));
      step();
    end
    clr();

    // pointer to 1 so requester 1 wins the burst start
    rq(0, 0, 0, 3'd1, 12'h200, '0);
    #1 chk("p3_gnt", 32'(bus.gnt), 32'h1);
    step(); clr();

    // 3: locked 4-read burst by requester 1 against competitors
    for (int k = 0; k < 6; k++) begin
      rq(0, 0, 0, 3'd1, 12'h300, '0);
      rq(2, 0, 0, 3'd5, 12'h301, '0);
      if (k < 4) rq(1, 0, lk3[k], 3'd3, adr3[k], '0);
      else t_req[1] = 1'b0;
      #1 chk("t3_gnt", 32'(bus.gnt), 32'(seq3[k]));
      step();
    end
    clr();
    step(); step();

    // 4: write then read-back at the top address
    rq(0, 1, 0, 3'd1, 12'hFFF, 20'h0A89E);
    #1 chk("t4_gnt", 32'(bus.gnt), 32'h1);
    step(); clr();
    chk("t4_cwr", 32'(bus.cwr), 32'd1);
    chk("t4_caddr_wr", 32'(bus.caddr_wr), 32'hFFF);
    chk("t4_cdata_wr", 32'(bus.cdata_wr), 32'h0A89E);
    rq(0, 0, 0, 3'd1, 12'hFFF, '0);
    step(); clr();
    step();
    chk("t4_rvalid", 32'(bus.rvalid), 32'h1);
    chk("t4_rdata", 32'(bus.rdata), 32'h0A89E);

    // read, write, read of one address keeps program order
    rq(0, 0, 1, 3'd2, 12'h010, '0); step();
    rq(0, 1, 0, 3'd2, 12'h010, 20'h12345); step();
    chk("ord_rdata_old", 32'(bus.rdata), 32'h5A5B5);
    rq(0, 0, 0, 3'd2, 12'h010, '0); step(); clr();
    step();
    chk("ord_rdata_new", 32'(bus.rdata), 32'h12345);

    // 5: locked owner drops its request
    rq(2, 0, 1, 3'd4, 12'h020, '0);
    #1 chk("t5_gnt_a", 32'(bus.gnt), 32'h4);
    step();
    rq(0, 0, 0, 3'd1, 12'h021, '0);
    t_addr[2] = 12'h022;
    #1 chk("t5_gnt_locked", 32'(bus.gnt), 32'h4);
    step();
    t_req[2] = 1'b0;
    #1 chk("t5_gnt_drop", 32'(bus.gnt), 32'h0);
    step();
    #1 chk("t5_gnt_next", 32'(bus.gnt), 32'h1);
    step(); clr();

    // reset in the middle of a locked read burst
    rq(1, 0, 1, 3'd3, 12'h030, '0); step();
    t_addr[1] = 12'h031; step();
    chk("t5_crd_pre", 32'(bus.crd), 32'd1);
    chk("t5_rvalid_pre", 32'(bus.rvalid), 32'h2);
    #1 reset = 1'b1; clr();
    #1;
    chk("t5_crd_async", 32'(bus.crd), 32'd0);
    chk("t5_rvalid_async", 32'(bus.rvalid), 32'd0);
    step(); step();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t5_no_rvalid", 32'(bus.rvalid), 32'd0);
    end

    // 6: sticky err_sel on select 0, then boundary selects 5 (legal) and 6 (illegal)
    rq(1, 0, 0, 3'd0, 12'h050, '0); step(); clr();
    chk("t6_err_set", 32'(bus.err_sel), 32'd1);
    rq(0, 1, 0, 3'd1, 12'h051, 20'h00001); step();
    rq(2, 0, 0, 3'd5, 12'h052, '0); step(); clr();
    step();
    chk("t6_err_sticky", 32'(bus.err_sel), 32'd1);
    reset = 1'b1; step();
    chk("t6_err_reset", 32'(bus.err_sel), 32'd0);
    reset = 1'b0; step();
    rq(2, 0, 0, 3'd5, 12'h053, '0); step(); clr();
    step();
    chk("t6_sel5_ok", 32'(bus.err_sel), 32'd0);
    rq(0, 0, 0, 3'd6, 12'h054, '0); step(); clr();
    chk("t6_sel6_err", 32'(bus.err_sel), 32'd1);
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
